// File: rtl/cv32e40p_mult_arbiter_if.sv
// rtl/cv32e40p_mult_arbiter_if.sv - requester command/response bus of the shared multiplier arbiter
interface cv32e40p_mult_arbiter_if;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][2:0]  req_op_i;
  logic [1:0][1:0]  req_signed_i;
  logic [1:0]       req_subword_i;
  logic [1:0][4:0]  req_imm_i;
  logic [1:0][31:0] req_op_a_i;
  logic [1:0][31:0] req_op_b_i;
  logic [1:0][31:0] req_op_c_i;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i;
  logic [31:0]      rsp_result_o;

  modport master (
    output req_valid_i, req_op_i, req_signed_i, req_subword_i, req_imm_i,
           req_op_a_i, req_op_b_i, req_op_c_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_signed_i, req_subword_i, req_imm_i,
           req_op_a_i, req_op_b_i, req_op_c_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o
  );
endinterface

// File: rtl/cv32e40p_mult_arbiter.sv
// rtl/cv32e40p_mult_arbiter.sv - shares one cv32e40p_mult between core EX and the aux port
module cv32e40p_mult_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  cv32e40p_mult_arbiter_if.slave        bus,
  output logic                          mult_enable_o,
  output logic [2:0]                    mult_operator_o,
  output logic [1:0]                    mult_short_signed_o,
  output logic                          mult_short_subword_o,
  output logic [4:0]                    mult_imm_o,
  output logic [31:0]                   mult_op_a_o,
  output logic [31:0]                   mult_op_b_o,
  output logic [31:0]                   mult_op_c_o,
  input  logic [31:0]                   mult_result_i,
  input  logic                          mult_ready_i,
  output logic                          mult_ex_ready_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      r_state;
  logic [2:0]  r_op;
  logic [1:0]  r_signed;
  logic        r_subword;
  logic [4:0]  r_imm;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_op_c;
  logic [31:0] r_result;
  logic        r_owner;
  logic        r_last;
  logic        r_kill;
  logic        r_enable;
  logic [1:0]  r_rsp_valid;

  logic        w_grant;
  logic        w_accept;
  logic [1:0]  w_req_ready;

  // On contention round-robin favours the requester not served last time.
  always_comb begin
    w_grant = bus.req_valid_i[1] & ~bus.req_valid_i[0];
    if (bus.req_valid_i == 2'b11) begin
      w_grant = RR_EN ? ~r_last : 1'b0;
    end
    w_req_ready = 2'b00;
    if ((r_state == IDLE) && !flush_i) begin
      w_req_ready[w_grant] = bus.req_valid_i[w_grant];
    end
  end

  assign w_accept = |w_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= 3'd0;
      r_signed    <= 2'd0;
      r_subword   <= 1'b0;
      r_imm       <= 5'd0;
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_op_c      <= 32'd0;
      r_result    <= 32'd0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_kill      <= 1'b0;
      r_enable    <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= bus.req_op_i[w_grant];
            r_signed  <= bus.req_signed_i[w_grant];
            r_subword <= bus.req_subword_i[w_grant];
            r_imm     <= bus.req_imm_i[w_grant];
            r_op_a    <= bus.req_op_a_i[w_grant];
            r_op_b    <= bus.req_op_b_i[w_grant];
            r_op_c    <= bus.req_op_c_i[w_grant];
            r_owner   <= w_grant;
            r_last    <= w_grant;
            r_kill    <= 1'b0;
            r_enable  <= 1'b1;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          // A killed op still runs to FINISH so the mult never stalls mid-MULH.
          if (flush_i) begin
            r_kill <= 1'b1;
          end
          if (mult_ready_i) begin
            r_result <= mult_result_i;
            r_enable <= 1'b0;
            if (r_kill || flush_i) begin
              r_state <= IDLE;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            end
          end
        end
        RESP: begin
          if (flush_i || bus.rsp_ready_i[r_owner]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = w_req_ready;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_result_o = r_result;

  assign mult_enable_o        = r_enable;
  assign mult_operator_o      = r_op;
  assign mult_short_signed_o  = r_signed;
  assign mult_short_subword_o = r_subword;
  assign mult_imm_o           = r_imm;
  assign mult_op_a_o          = r_op_a;
  assign mult_op_b_o          = r_op_b;
  assign mult_op_c_o          = r_op_c;
  assign mult_ex_ready_o      = (r_state == BUSY) ? mult_ready_i : 1'b1;

endmodule
